// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - round-robin arbiter sharing one data-memory port among LSUs
// Grants are held until the requesting LSU drops its valid, then the pointer moves past it.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 12,
  parameter int DATA_BITS     = 16,
  localparam int ID_BITS      = $clog2(NUM_CONSUMERS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready,
  output logic                                 busy,
  output logic [ID_BITS-1:0]                   grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELEASE,
    WRITE_RELEASE
  } state_t;

  state_t                             state, state_n;
  logic [ID_BITS-1:0]                 rr_ptr, rr_ptr_n;
  logic [ID_BITS-1:0]                 grant_id_n;
  logic [ID_BITS-1:0]                 next_ptr;
  logic [ID_BITS-1:0]                 pick_idx;
  logic                               pick_found;
  logic [ID_BITS:0]                   cand;
  logic [NUM_CONSUMERS-1:0]           req;
  logic                               busy_n;
  logic                               mem_read_valid_n, mem_write_valid_n;
  logic [ADDR_BITS-1:0]               mem_read_address_n, mem_write_address_n;
  logic [DATA_BITS-1:0]               mem_write_data_n;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_n, consumer_write_ready_n;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_n;

  assign req      = consumer_read_valid | consumer_write_valid;
  assign next_ptr = (grant_id == ID_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant_id + 1'b1;

  // Walk offsets from farthest to nearest so the consumer closest to rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + k[ID_BITS:0];
      if (cand >= (ID_BITS+1)'(NUM_CONSUMERS))
        cand = cand - (ID_BITS+1)'(NUM_CONSUMERS);
      if (req[cand[ID_BITS-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[ID_BITS-1:0];
      end
    end
  end

  always_comb begin
    state_n                = state;
    rr_ptr_n               = rr_ptr;
    grant_id_n             = grant_id;
    mem_read_valid_n       = mem_read_valid;
    mem_write_valid_n      = mem_write_valid;
    mem_read_address_n     = mem_read_address;
    mem_write_address_n    = mem_write_address;
    mem_write_data_n       = mem_write_data;
    consumer_read_ready_n  = consumer_read_ready;
    consumer_write_ready_n = consumer_write_ready;
    consumer_read_data_n   = consumer_read_data;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_id_n = pick_idx;
          // A consumer asking for both is served read-first; its write is re-arbitrated later.
          if (consumer_read_valid[pick_idx]) begin
            mem_read_valid_n   = 1'b1;
            mem_read_address_n = consumer_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
            state_n            = READ_WAIT;
          end else begin
            mem_write_valid_n   = 1'b1;
            mem_write_address_n = consumer_write_address[pick_idx*ADDR_BITS +: ADDR_BITS];
            mem_write_data_n    = consumer_write_data[pick_idx*DATA_BITS +: DATA_BITS];
            state_n             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_n = 1'b0;
          consumer_read_data_n[grant_id*DATA_BITS +: DATA_BITS] = mem_read_data;
          consumer_read_ready_n[grant_id] = 1'b1;
          state_n = READ_RELEASE;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_n = 1'b0;
          consumer_write_ready_n[grant_id] = 1'b1;
          state_n = WRITE_RELEASE;
        end
      end
      READ_RELEASE: begin
        if (!consumer_read_valid[grant_id]) begin
          consumer_read_ready_n[grant_id] = 1'b0;
          rr_ptr_n = next_ptr;
          state_n  = IDLE;
        end
      end
      WRITE_RELEASE: begin
        if (!consumer_write_valid[grant_id]) begin
          consumer_write_ready_n[grant_id] = 1'b0;
          rr_ptr_n = next_ptr;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant_id             <= '0;
      busy                 <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_write_valid      <= 1'b0;
      mem_read_address     <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      state                <= state_n;
      rr_ptr               <= rr_ptr_n;
      grant_id             <= grant_id_n;
      busy                 <= busy_n;
      mem_read_valid       <= mem_read_valid_n;
      mem_write_valid      <= mem_write_valid_n;
      mem_read_address     <= mem_read_address_n;
      mem_write_address    <= mem_write_address_n;
      mem_write_data       <= mem_write_data_n;
      consumer_read_ready  <= consumer_read_ready_n;
      consumer_write_ready <= consumer_write_ready_n;
      consumer_read_data   <= consumer_read_data_n;
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - randomized and directed bench for lsu_mem_arbiter
// LSU and memory agents drive traffic; a transaction-rule model predicts every output cycle.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    c_rv = '0, c_wv = '0;
  logic [N*AW-1:0] c_raddr = '0, c_waddr = '0;
  logic [N*DW-1:0] c_wdata = '0;
  logic [N-1:0]    c_rrdy, c_wrdy;
  logic [N*DW-1:0] c_rdata;
  logic            m_rv, m_wv;
  logic [AW-1:0]   m_raddr, m_waddr;
  logic [DW-1:0]   m_wdata;
  logic            m_rrdy = 1'b0, m_wrdy = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic            busy;
  logic [1:0]      gid;

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c_rv), .consumer_read_address(c_raddr),
    .consumer_read_ready(c_rrdy), .consumer_read_data(c_rdata),
    .consumer_write_valid(c_wv), .consumer_write_address(c_waddr),
    .consumer_write_data(c_wdata), .consumer_write_ready(c_wrdy),
    .mem_read_valid(m_rv), .mem_read_address(m_raddr),
    .mem_read_ready(m_rrdy), .mem_read_data(m_rdata),
    .mem_write_valid(m_wv), .mem_write_address(m_waddr),
    .mem_write_data(m_wdata), .mem_write_ready(m_wrdy),
    .busy(busy), .grant_id(gid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: transaction phase 0 = free, 1 = memory outstanding, 2 = awaiting release.
  int            md_phase = 0, md_gid = 0, md_rr = 0;
  bit            md_read = 1'b0;
  bit            e_rv = 1'b0, e_wv = 1'b0;
  logic [AW-1:0] e_raddr = '0, e_waddr = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [N-1:0]  e_rrdy = '0, e_wrdy = '0;
  logic [DW-1:0] e_rdata [N];
  int            grant_log[$];

  logic [DW-1:0] tb_mem [4096];
  int            r_ph[N], r_cnt[N], w_ph[N], w_cnt[N];
  logic [AW-1:0] r_a[N], w_a[N];
  logic [DW-1:0] w_d[N];
  bit            auto_en = 1'b0, spur_en = 1'b0;
  int            rel_fixed = 1, mem_dly_fixed = 1, r_wait = 1, w_wait = 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    if (reset) begin
      md_phase = 0; md_rr = 0; md_gid = 0;
      e_rv = 0; e_wv = 0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
      e_rrdy = '0; e_wrdy = '0;
      foreach (e_rdata[i]) e_rdata[i] = '0;
      return;
    end
    if (md_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int c = (md_rr + k) % N;
        if (c_rv[c] || c_wv[c]) begin
          md_gid = c; md_read = c_rv[c]; md_phase = 1;
          if (md_read) begin
            e_rv = 1; e_raddr = c_raddr[c*AW +: AW];
          end else begin
            e_wv = 1; e_waddr = c_waddr[c*AW +: AW]; e_wdata = c_wdata[c*DW +: DW];
          end
          grant_log.push_back(md_read ? c : c + 8);
          break;
        end
      end
    end else if (md_phase == 1) begin
      if (md_read ? m_rrdy : m_wrdy) begin
        md_phase = 2;
        if (md_read) begin
          e_rv = 0; e_rdata[md_gid] = m_rdata; e_rrdy[md_gid] = 1'b1;
        end else begin
          e_wv = 0; e_wrdy[md_gid] = 1'b1;
        end
      end
    end else if (!(md_read ? c_rv[md_gid] : c_wv[md_gid])) begin
      e_rrdy = '0; e_wrdy = '0; md_rr = (md_gid + 1) % N; md_phase = 0;
    end
  endtask

  task automatic compare();
    check_eq("mem_read_valid", m_rv, e_rv);
    check_eq("mem_write_valid", m_wv, e_wv);
    if (e_rv) check_eq("mem_read_address", m_raddr, e_raddr);
    if (e_wv) begin
      check_eq("mem_write_address", m_waddr, e_waddr);
      check_eq("mem_write_data", m_wdata, e_wdata);
    end
    check_eq("consumer_read_ready", c_rrdy, e_rrdy);
    check_eq("consumer_write_ready", c_wrdy, e_wrdy);
    check_eq("grant_id", gid, md_gid);
    check_eq("busy", busy, md_phase != 0);
    for (int i = 0; i < N; i++) check_eq("consumer_read_data", c_rdata[i*DW +: DW], e_rdata[i]);
  endtask

  function automatic int mem_delay();
    return (mem_dly_fixed >= 0) ? mem_dly_fixed : int'($urandom_range(0, 4));
  endfunction

  function automatic int rel_delay();
    return (rel_fixed >= 0) ? rel_fixed : int'($urandom_range(0, 2));
  endfunction

  task automatic mem_respond();
    if (m_rrdy) m_rrdy = 1'b0;
    else if (m_rv) begin
      if (r_wait == 0) begin m_rrdy = 1'b1; m_rdata = tb_mem[m_raddr]; r_wait = mem_delay(); end
      else r_wait--;
    end else if (spur_en && $urandom_range(0, 7) == 0) m_rrdy = 1'b1;
    if (!m_rrdy || !m_rv) m_rdata = DW'($urandom);
    if (m_wrdy) m_wrdy = 1'b0;
    else if (m_wv) begin
      if (w_wait == 0) begin m_wrdy = 1'b1; tb_mem[m_waddr] = m_wdata; w_wait = mem_delay(); end
      else w_wait--;
    end else if (spur_en && $urandom_range(0, 7) == 0) m_wrdy = 1'b1;
  endtask

  task automatic start_read(input int i, input logic [AW-1:0] a);
    c_rv[i] = 1'b1; c_raddr[i*AW +: AW] = a; r_a[i] = a; r_ph[i] = 1;
  endtask

  task automatic start_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_wv[i] = 1'b1; c_waddr[i*AW +: AW] = a; c_wdata[i*DW +: DW] = d;
    w_a[i] = a; w_d[i] = d; w_ph[i] = 1;
  endtask

  task automatic agents();
    for (int i = 0; i < N; i++) begin
      case (r_ph[i])
        0: if (r_cnt[i] > 0) r_cnt[i]--;
           else if (auto_en && $urandom_range(0, 3) == 0) start_read(i, AW'($urandom));
        1: if (c_rrdy[i]) begin
             check_eq("e2e_read_data", c_rdata[i*DW +: DW], tb_mem[r_a[i]]);
             r_cnt[i] = rel_delay(); r_ph[i] = 2;
             if (r_cnt[i] == 0) begin c_rv[i] = 1'b0; r_ph[i] = 0; r_cnt[i] = 1 + $urandom_range(0, 3); end
           end
        default: begin
          r_cnt[i]--;
          if (r_cnt[i] <= 0) begin c_rv[i] = 1'b0; r_ph[i] = 0; r_cnt[i] = 1 + $urandom_range(0, 3); end
        end
      endcase
      case (w_ph[i])
        0: if (w_cnt[i] > 0) w_cnt[i]--;
           else if (auto_en && $urandom_range(0, 5) == 0) start_write(i, AW'($urandom), DW'($urandom));
        1: if (c_wrdy[i]) begin
             check_eq("e2e_write_data", tb_mem[w_a[i]], w_d[i]);
             w_cnt[i] = rel_delay(); w_ph[i] = 2;
             if (w_cnt[i] == 0) begin c_wv[i] = 1'b0; w_ph[i] = 0; w_cnt[i] = 1 + $urandom_range(0, 3); end
           end
        default: begin
          w_cnt[i]--;
          if (w_cnt[i] <= 0) begin c_wv[i] = 1'b0; w_ph[i] = 0; w_cnt[i] = 1 + $urandom_range(0, 3); end
        end
      endcase
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    compare();
    mem_respond();
    agents();
  endtask

  task automatic set_mem_delay(input int d);
    mem_dly_fixed = d; r_wait = mem_delay(); w_wait = mem_delay();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c_rv = '0; c_wv = '0; m_rrdy = 1'b0; m_wrdy = 1'b0;
    for (int i = 0; i < N; i++) begin r_ph[i] = 0; w_ph[i] = 0; r_cnt[i] = 0; w_cnt[i] = 0; end
    r_wait = mem_delay(); w_wait = mem_delay();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int  n = 0;
    bit  done = 1'b0;
    while (n < limit && !done) begin
      step();
      n++;
      done = (md_phase == 0);
      for (int i = 0; i < N; i++) if (r_ph[i] != 0 || w_ph[i] != 0) done = 1'b0;
    end
    check_eq(tag, done, 1'b1);
  endtask

  task automatic check_log(input string tag, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int e[4] = '{e0, e1, e2, e3};
    check_eq({tag, "_grant_count"}, grant_log.size(), n);
    for (int k = 0; k < n; k++)
      if (k < grant_log.size()) check_eq({tag, "_grant_order"}, grant_log[k], e[k]);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) tb_mem[a] = DW'($urandom);
    do_reset();
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_grant_id", gid, 2'd0);
    check_eq("reset_mem_valids", {m_rv, m_wv}, 2'b00);
    check_eq("reset_readies", {c_rrdy, c_wrdy}, 8'h00);

    // Consumer 2 reads 0x05A; memory answers 0x4000 after a stall.
    set_mem_delay(3); rel_fixed = 1; grant_log.delete();
    tb_mem[12'h05A] = 16'h4000;
    start_read(2, 12'h05A);
    step();
    check_eq("d1_mem_read_valid", m_rv, 1'b1);
    check_eq("d1_mem_read_address", m_raddr, 12'h05A);
    begin
      int n = 0;
      while (!c_rrdy[2] && n < 20) begin step(); n++; end
    end
    check_eq("d1_read_ready", c_rrdy[2], 1'b1);
    check_eq("d1_read_data", c_rdata[2*DW +: DW], 16'h4000);
    check_eq("d1_grant_id", gid, 2'd2);
    wait_idle(50, "d1_idle");

    // rr_ptr is now 3: consumer 3 beats consumer 1 (wrap-around).
    grant_log.delete(); set_mem_delay(1);
    start_read(1, AW'($urandom)); start_read(3, AW'($urandom));
    wait_idle(100, "d4_idle");
    check_log("d4", 2, 3, 1, 0, 0);

    // Consumer 0 writes 0x7FFF to 0x010.
    grant_log.delete();
    start_write(0, 12'h010, 16'h7FFF);
    step();
    check_eq("d2_mem_write_valid", m_wv, 1'b1);
    check_eq("d2_mem_write_address", m_waddr, 12'h010);
    check_eq("d2_mem_write_data", m_wdata, 16'h7FFF);
    check_eq("d2_no_read", m_rv, 1'b0);
    wait_idle(50, "d2_idle");
    check_eq("d2_mem_content", tb_mem[12'h010], 16'h7FFF);
    check_log("d2", 1, 8, 0, 0, 0);

    // All four read at once from rr_ptr=0.
    do_reset(); grant_log.delete();
    for (int i = 0; i < N; i++) start_read(i, AW'($urandom));
    wait_idle(200, "d3_idle");
    check_log("d3", 4, 0, 1, 2, 3);

    // Consumer 1 reads and writes together: read first, write on a later pass.
    grant_log.delete();
    start_read(1, AW'($urandom)); start_write(1, AW'($urandom), DW'($urandom));
    wait_idle(100, "d5_idle");
    check_log("d5", 2, 1, 9, 0, 0);

    // Reset during READ_WAIT aborts; afterwards arbitration restarts at consumer 0.
    set_mem_delay(10);
    start_read(3, AW'($urandom));
    step();
    check_eq("d6_granted", m_rv, 1'b1);
    step();
    do_reset();
    check_eq("d6_mem_read_valid", m_rv, 1'b0);
    check_eq("d6_busy", busy, 1'b0);
    check_eq("d6_readies", {c_rrdy, c_wrdy}, 8'h00);
    grant_log.delete(); set_mem_delay(1);
    start_read(3, AW'($urandom)); start_read(0, AW'($urandom));
    wait_idle(100, "d6_idle");
    check_log("d6", 2, 0, 3, 0, 0);

    // Randomized traffic with stalls, spurious memory readies and occasional resets.
    set_mem_delay(-1); rel_fixed = -1; spur_en = 1'b1; auto_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end
    auto_en = 1'b0;
    wait_idle(1000, "drain_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
